i2s_clk_gen: RTL

I2S master clock generator driven by the on-chip oscillator clock. It divides the oscillator output into the I2S serial clock (SCK) and word-select (WS) for the microphone array, and gives the capture logic single-cycle strobes aligned to every SCK edge. It holds off a `running` indication until the microphones' start-up frames have elapsed, and it starts and stops only on frame boundaries so SCK never glitches.

---
 rtl/i2s_clk_gen_pkg.sv | 28 ++
 rtl/i2s_clk_gen_sck_divider.sv | 70 +++++++
 rtl/i2s_clk_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/i2s_clk_gen_pkg.sv
`default_nettype none
// =============================================================================
// Module : i2s_pkg
// Shared state encoding, parameter defaults and width helper for i2s_clk_gen.
// Rev    : 1.0
// =============================================================================
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_STOP   = 2'd3
   } i2s_state_e;

   localparam int unsigned DEF_BITS_PER_SLOT = 32;
   localparam int unsigned DEF_WARMUP_FRAMES = 4096;

   // Ceiling log2, floored at 1 so a single-entry range still gets a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen_sck_divider.sv
`default_nettype none
// =============================================================================
// Module : sck_divider
// Divides clk into SCK with half-period h and emits registered rise/fall strobes.
// Rev    : 1.0
// =============================================================================
module sck_divider
   import i2s_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] h,
   output logic                 sck,
   output logic                 sck_rise,
   output logic                 sck_fall,
   output logic                 fall_next
);

   localparam logic [DIV_WIDTH-1:0] c_one = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sck_q, sck_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 last;

   assign last = (cnt_q == (h - c_one));

   // Deliberately not gated by run: the FSM uses it to compute run itself.
   assign fall_next = last && sck_q;

   always_comb begin
      cnt_d  = cnt_q + c_one;
      sck_d  = sck_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!run) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (last) begin
         cnt_d  = '0;
         sck_d  = ~sck_q;
         rise_d = ~sck_q;
         fall_d = sck_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sck_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sck_q  <= sck_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sck      = sck_q;
   assign sck_rise = rise_q;
   assign sck_fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// =============================================================================
// Module : i2s_clk_gen
// I2S master SCK/WS generator with warm-up hold-off and frame-aligned start/stop.
// Rev    : 1.0
// =============================================================================
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned DIV_WIDTH     = 8,
   parameter int unsigned BITS_PER_SLOT = DEF_BITS_PER_SLOT,
   parameter int unsigned WARMUP_FRAMES = DEF_WARMUP_FRAMES
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [DIV_WIDTH-1:0]             half_div,
   output logic                             sck,
   output logic                             ws,
   output logic                             sck_rise,
   output logic                             sck_fall,
   output logic [clog2(BITS_PER_SLOT)-1:0]  bit_idx,
   output logic                             frame_start,
   output logic                             running,
   output logic                             busy
);

   localparam int unsigned BW = clog2(BITS_PER_SLOT);
   localparam int unsigned FW = clog2(WARMUP_FRAMES);

   localparam logic [BW-1:0]        c_last_bit   = BW'(BITS_PER_SLOT - 1);
   localparam logic [BW-1:0]        c_bit_one    = BW'(1);
   localparam logic [FW-1:0]        c_last_frame = FW'(WARMUP_FRAMES - 1);
   localparam logic [FW-1:0]        c_frame_one  = FW'(1);
   localparam logic [DIV_WIDTH-1:0] c_div_one    = DIV_WIDTH'(1);

   i2s_state_e           state_q, state_d;
   logic [DIV_WIDTH-1:0] h_q, h_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 ws_q, ws_d;
   logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
   logic                 fs_q, fs_d;

   logic                 div_run;
   logic                 fall_next;
   logic                 boundary;
   logic                 stop_done;

   sck_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_sck_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (div_run),
      .h         (h_q),
      .sck       (sck),
      .sck_rise  (sck_rise),
      .sck_fall  (sck_fall),
      .fall_next (fall_next)
   );

   // The coming falling edge will move ws from right back to left.
   assign boundary  = fall_next && (bit_q == c_last_bit) && ws_q;
   // Only a boundary cycle shows a fresh fall with ws=0 and bit_idx=0.
   assign stop_done = sck_fall && !ws_q && (bit_q == '0);

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_WARMUP;
               h_d     = (half_div == '0) ? c_div_one : half_div;
            end
         end
         ST_WARMUP: begin
            if (!enable)
               state_d = ST_STOP;
            else if (boundary && (frame_cnt_q == c_last_frame))
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (stop_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bit_d       = bit_q;
      ws_d        = ws_q;
      frame_cnt_d = frame_cnt_q;
      if (state_q == ST_IDLE) begin
         bit_d       = '0;
         ws_d        = 1'b0;
         frame_cnt_d = '0;
      end else begin
         if (fall_next) begin
            if (bit_q == c_last_bit) begin
               bit_d = '0;
               ws_d  = ~ws_q;
            end else begin
               bit_d = bit_q + c_bit_one;
            end
         end
         if ((state_q == ST_WARMUP) && boundary)
            frame_cnt_d = frame_cnt_q + c_frame_one;
      end
      fs_d = boundary && (state_d == ST_RUN);
   end

   // Hold the divider cleared on both the entry and exit edges of IDLE.
   assign div_run = (state_q != ST_IDLE) && (state_d != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         h_q         <= c_div_one;
         bit_q       <= '0;
         ws_q        <= 1'b0;
         frame_cnt_q <= '0;
         fs_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         bit_q       <= bit_d;
         ws_q        <= ws_d;
         frame_cnt_q <= frame_cnt_d;
         fs_q        <= fs_d;
      end
   end

   assign ws          = ws_q;
   assign bit_idx     = bit_q;
   assign frame_start = fs_q;
   assign running     = (state_q == ST_RUN);
   assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
